// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: divider state encoding and default widths.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } div_state_t;

    localparam int DIV_DW = 8;
    localparam int DIV_VW = 4;

    function automatic int div_cnt_w(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtraction r - {0,divisor} for the restoring divider, built as r + ~d + 1.
module div_trial_sub #(
    parameter int VW = 4
) (
    input  logic [VW:0]   i_r,
    input  logic [VW-1:0] i_divisor,
    output logic [VW-1:0] o_diff,
    output logic          o_borrow
);

    logic [VW:0]   w_b_inv;
    logic [VW:0]   w_sum;
    logic [VW+1:0] w_carry;
    logic          w_unused_msb;

    assign w_b_inv    = ~{1'b0, i_divisor};
    assign w_carry[0] = 1'b1;

    for (genvar g = 0; g <= VW; g++) begin : gen_fa
        full_adder u_fa (
            .i_a  (i_r[g]),
            .i_b  (w_b_inv[g]),
            .i_ci (w_carry[g]),
            .o_s  (w_sum[g]),
            .o_co (w_carry[g+1])
        );
    end

    // A kept difference is always below the divisor, so its MSB is never needed.
    assign o_diff       = w_sum[VW-1:0];
    assign w_unused_msb = w_sum[VW];
    assign o_borrow     = ~w_carry[VW+1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used by the arithmetic datapath.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock behind a start/done handshake.
//   state | meaning
//   IDLE  | waiting for start; results held
//   CALC  | shifting in dividend bits, one trial subtraction per cycle
//   FIN   | publishing results, done pulses on the following cycle
module seq_divider
    import arith_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [DW-1:0] i_dividend,
    input  logic [VW-1:0] i_divisor,
    output logic          o_busy,
    output logic          o_done,
    output logic [DW-1:0] o_quotient,
    output logic [VW-1:0] o_remainder,
    output logic          o_div_zero
);

    localparam int CW = div_cnt_w(DW);

    div_state_t    r_state;
    div_state_t    w_state_nxt;
    logic [DW-1:0] r_dvd;
    logic [VW-1:0] r_dvs;
    logic [VW-1:0] r_rem;
    logic [CW-1:0] r_cnt;
    logic          r_dz;

    logic          w_accept;
    logic          w_step;
    logic          w_fin;
    logic [VW:0]   w_trial_r;
    logic [VW-1:0] w_diff;
    logic          w_borrow;
    logic          w_qbit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = (i_divisor == '0) ? FIN : CALC;
            CALC:    if (r_cnt == '0) w_state_nxt = FIN;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy   = (r_state != IDLE);
        w_accept = (r_state == IDLE) && i_start;
        w_step   = (r_state == CALC);
        w_fin    = (r_state == FIN);
    end

    assign w_trial_r = {r_rem, r_dvd[DW-1]};
    assign w_qbit    = ~w_borrow;

    div_trial_sub #(.VW(VW)) u_trial (
        .i_r       (w_trial_r),
        .i_divisor (r_dvs),
        .o_diff    (w_diff),
        .o_borrow  (w_borrow)
    );

    // Quotient bits shift into the dividend register as dividend bits shift out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dvd <= '0;
            r_dvs <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            r_dz  <= 1'b0;
        end else if (w_accept) begin
            r_dvd <= i_dividend;
            r_dvs <= i_divisor;
            r_rem <= '0;
            r_cnt <= CW'(DW - 1);
            r_dz  <= (i_divisor == '0);
        end else if (w_step) begin
            r_dvd <= {r_dvd[DW-2:0], w_qbit};
            r_rem <= w_qbit ? w_diff : w_trial_r[VW-1:0];
            if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_done      <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_div_zero  <= 1'b0;
        end else begin
            o_done <= w_fin;
            if (w_fin) begin
                o_quotient  <= r_dz ? {DW{1'b1}} : r_dvd;
                o_remainder <= r_dz ? r_dvd[VW-1:0] : r_rem;
                o_div_zero  <= r_dz;
            end
        end
    end

endmodule
